// File: rtl/uart_rx_if.sv
// Receive-side bundle of uart_rx_fifo: serial input, FIFO head stream and status.
// master = receiver (drives the stream), slave = consumer.
interface uart_rx_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                 rx;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_parity_err;
  logic                 m_frame_err;
  logic                 m_valid;
  logic                 m_ready;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overrun;
  logic                 clr_overrun;
  logic                 busy;

  modport master (
    input  rx, m_ready, clr_overrun,
    output m_data, m_parity_err, m_frame_err, m_valid, fifo_count, overrun, busy
  );

  modport slave (
    output rx, m_ready, clr_overrun,
    input  m_data, m_parity_err, m_frame_err, m_valid, fifo_count, overrun, busy
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with majority-vote sampling, parity/framing/break
// handling and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int H   = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam int EW  = DATA_BITS + 2;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CW-1:0] SAMP0     = CW'(H - 1);
  localparam logic [CW-1:0] SAMP1     = CW'(H);
  localparam logic [CW-1:0] DECIDE    = CW'(H + 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CPB - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  logic [1:0]           sync_q, sync_d;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ones_q, ones_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic [FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [NW-1:0]        count_q, count_d;
  logic                 ovr_q, ovr_d;

  logic          rx_s, maj, decide, end_of_bit, push;
  logic [EW-1:0] entry;
  logic          full, valid, pop, wr_en;

  assign rx_s       = sync_q[1];
  assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
  assign decide     = (cnt_q == DECIDE);
  assign end_of_bit = (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    sync_d  = {sync_q[0], bus.rx};
    state_d = state_q;
    cnt_d   = end_of_bit ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    ones_d  = ones_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;

    if (cnt_q == SAMP0) samp_d[0] = rx_s;
    if (cnt_q == SAMP1) samp_d[1] = rx_s;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        ones_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (decide && maj)   state_d = S_IDLE;
        else if (end_of_bit) state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          ones_d  = ones_q ^ maj;
        end
        if (end_of_bit) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        // ones_q ^ maj is 1 when data plus parity bit hold an odd number of ones.
        if (decide) perr_d = (PARITY == 1) ? ~(ones_q ^ maj) : (ones_q ^ maj);
        if (end_of_bit) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          if (!maj) ferr_d = 1'b1;
          if (bit_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = (ferr_q || !maj) ? S_BREAK : S_IDLE;
          end
        end else if (end_of_bit) begin
          bit_d = bit_q + 4'd1;
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign entry = {ferr_d, perr_q, shift_q};

  always_comb begin
    full    = (count_q == NW'(FIFO_DEPTH));
    valid   = (count_q != '0);
    pop     = valid && bus.m_ready;
    wr_en   = push && (!full || pop);
    mem_d   = mem_q;
    if (wr_en) mem_d[wr_q] = entry;
    wr_d    = wr_q + PW'(wr_en);
    rd_d    = rd_q + PW'(pop);
    count_d = count_q + NW'(wr_en) - NW'(pop);
    if (push && !wr_en)        ovr_d = 1'b1;
    else if (bus.clr_overrun)  ovr_d = 1'b0;
    else                       ovr_d = ovr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      samp_q  <= '0;
      shift_q <= '0;
      ones_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      // NOTE: the storage is reset too so the fall-through head reads 0 after reset, not X.
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      samp_q  <= samp_d;
      shift_q <= shift_d;
      ones_q  <= ones_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.m_data       = mem_q[rd_q][DATA_BITS-1:0];
  assign bus.m_parity_err = mem_q[rd_q][DATA_BITS];
  assign bus.m_frame_err  = mem_q[rd_q][DATA_BITS+1];
  assign bus.m_valid      = valid;
  assign bus.fifo_count   = count_q;
  assign bus.overrun      = ovr_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver in the guess-the-number project. Supports configurable data width, parity and stop bits. Adds a 2-flop input synchroniser, 3-sample majority voting, parity and framing error flags, and break handling. Received frames go into a small first-word-fall-through FIFO, read through a valid/ready handshake by the game controller.

Parameters:
CLK_FREQ, 50000000, system clock in Hz
BAUD, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 8); H = CLKS_PER_BIT/2
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
rx  in  1  serial line, idles high, asynchronous to clk
m_data  out  DATA_BITS  data of FIFO head entry
m_parity_err  out  1  parity error flag of head entry (always 0 when PARITY=0)
m_frame_err  out  1  framing error flag of head entry
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts the head entry
fifo_count  out  $clog2(FIFO_DEPTH+1)  number of occupied entries
overrun  out  1  sticky: a completed frame was dropped because the FIFO was full
clr_overrun  in  1  clears overrun
busy  out  1  receiver FSM is not in IDLE

Behaviour:
- Reset (async, active-high): both synchroniser flops go to 1. FSM goes to IDLE and all counters to 0. FIFO is emptied. All outputs are 0. Any partial frame is discarded.
- rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Bit timing: bit counter cnt runs 0..CLKS_PER_BIT-1, restarting at 0 for each bit.
  - rx_s is sampled at cnt = H-1, H and H+1.
  - The bit value is the majority of the 3 samples and is decided at cnt = H+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when rx_s = 0, go to START with cnt = 0. busy = (state != IDLE).
  - START: if the majority is 1, this is a false start; return to IDLE at cnt = H+1. Otherwise continue to the end of the bit, then DATA.
  - DATA: receive DATA_BITS bits, LSB first, each shifted in at its decision point. Then go to PARITY if PARITY != 0, else STOP.
  - PARITY: take the majority sample. parity_err = 1 when the total count of ones over data plus parity bit is even for odd parity, or odd for even parity.
  - STOP: STOP_BITS bit periods. Any stop bit whose majority is 0 sets frame_err. At the decision point of the last stop bit, push {frame_err, parity_err, data} into the FIFO. Then go to IDLE if frame_err = 0, else BREAK. There is no wait for the end of the stop bit, which allows resync to a closely following start bit.
  - BREAK: wait until rx_s = 1, then go to IDLE. A held-low line therefore yields exactly one entry.
- FIFO:
  - First-word-fall-through: m_data and the m_* flags always reflect the head entry.
  - m_valid = (fifo_count != 0).
  - Pop when m_valid && m_ready.
  - A pushed entry is visible at the outputs on the cycle after the push.
  - Push while full with no pop in the same cycle: the entry is dropped and overrun is set.
  - Push and pop in the same cycle while full: both happen, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: the push is stored and the pop is ignored (m_valid was 0).
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overrun: sticky. clr_overrun clears it. If clr_overrun and a new overrun happen in the same cycle, set wins.
- m_data with DATA_BITS < 8: data is right-aligned, no padding bits.

Test Plan:
(Bench runs CLK_FREQ=16, BAUD=1, i.e. 16 clocks/bit, unless noted.)
1. 8N1, send 0xA5 with m_ready=0 -> m_valid rises once, m_data=0xA5, both error flags 0, fifo_count=1. Pulse m_ready for one cycle -> m_valid=0, count=0.
2. PARITY=2, DATA_BITS=7: send 0x03 with parity bit 1 -> m_parity_err=1, m_data=0x03. Resend with parity bit 0 -> m_parity_err=0.
3. Hold rx low for 30 bit times, then send 0x3C -> first entry is data 0x00 with m_frame_err=1, second entry is 0x3C clean. busy stays 1 until the line goes high.
4. Noise: rx low for 4 clocks only -> busy pulses, no entry. Send 0x81 with a 1-clock inverted glitch at cnt=H on bit 3 -> m_data=0x81.
5. FIFO_DEPTH=4, m_ready=0, send 0x11, 0x22, 0x33, 0x44, 0x55 -> count=4, overrun=1, pops return 0x11..0x44 in order. clr_overrun -> overrun=0.
6. Assert rst mid-data-bit, then release and send 0x5A -> no stale entry, only 0x5A received. STOP_BITS=2 with the second stop bit 0 -> m_frame_err=1.
